vec_result_writeback: RTL

//  Consumer of the vector ALU's widened result. Accepts one result (LANES lanes x 2*ELEM_W bits)
//  via valid/ready and writes it to the vector register file as ELEM_W*LANES-bit words.

---
 rtl/vp_pkg.sv | 14 +
 rtl/wb_lane_pack.sv | 23 ++
 rtl/vec_result_writeback.sv | 96 +++++++++
 3 files changed

// File: rtl/vp_pkg.sv
// Shared constants and state encoding for the vector result writeback path.
package vp_pkg;
  localparam int LANES  = 16;
  localparam int ELEM_W = 32;
  localparam int REG_AW = 2;
  localparam int VEC_W  = LANES * ELEM_W;
  localparam int RES_W  = 2 * VEC_W;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1
  } wb_state_t;
endpackage

// File: rtl/wb_lane_pack.sv
// Forms the two register-file words from a widened result: the first beat
// (full low half, or the low element of every lane packed) and the high half.
module wb_lane_pack #(
  parameter int LANES  = vp_pkg::LANES,
  parameter int ELEM_W = vp_pkg::ELEM_W
) (
  input  logic [2*LANES*ELEM_W-1:0] i_res,
  input  logic                      i_wide,
  output logic [LANES*ELEM_W-1:0]   o_beat0,
  output logic [LANES*ELEM_W-1:0]   o_beat1
);
  localparam int VEC_W = LANES * ELEM_W;

  logic [VEC_W-1:0] w_packed;

  // Narrow mode keeps only the low element of each double-width lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_packed[g*ELEM_W +: ELEM_W] = i_res[g*2*ELEM_W +: ELEM_W];
  end

  assign o_beat0 = i_wide ? i_res[VEC_W-1:0] : w_packed;
  assign o_beat1 = i_res[2*VEC_W-1:VEC_W];
endmodule

// File: rtl/vec_result_writeback.sv
// Accepts one widened vector ALU result and writes it to the register file
// as one packed beat (narrow) or two full beats to rd and rd+1 (wide).
module vec_result_writeback #(
  parameter int LANES  = vp_pkg::LANES,
  parameter int ELEM_W = vp_pkg::ELEM_W,
  parameter int REG_AW = vp_pkg::REG_AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [2*LANES*ELEM_W-1:0] res_data,
  input  logic [REG_AW-1:0]         res_rd,
  input  logic                      res_wide,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [LANES*ELEM_W-1:0]   rf_wdata,
  input  logic                      rf_gnt,
  output logic                      busy,
  output logic                      done
);
  localparam int VEC_W = LANES * ELEM_W;

  vp_pkg::wb_state_t r_state;
  logic              r_wide;
  logic [VEC_W-1:0]  r_hi;
  logic [VEC_W-1:0]  w_beat0;
  logic [VEC_W-1:0]  w_beat1;
  logic              w_final;
  logic              w_fin;
  logic              w_accept;

  wb_lane_pack #(
    .LANES  (LANES),
    .ELEM_W (ELEM_W)
  ) u_pack (
    .i_res   (res_data),
    .i_wide  (res_wide),
    .o_beat0 (w_beat0),
    .o_beat1 (w_beat1)
  );

  // A granted final beat frees the block in the same cycle for back-to-back results.
  assign w_final   = (r_state == vp_pkg::BEAT1) || ((r_state == vp_pkg::BEAT0) && !r_wide);
  assign w_fin     = w_final && rf_gnt;
  assign res_ready = !rst && ((r_state == vp_pkg::IDLE) || w_fin);
  assign w_accept  = res_valid && res_ready;
  assign busy      = (r_state != vp_pkg::IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= vp_pkg::IDLE;
      r_wide   <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      done     <= 1'b0;
    end else begin
      done <= w_fin;
      if (w_accept) begin
        r_state  <= vp_pkg::BEAT0;
        r_wide   <= res_wide;
        rf_we    <= 1'b1;
        rf_waddr <= res_rd;
        rf_wdata <= w_beat0;
      end else begin
        case (r_state)
          vp_pkg::BEAT0: begin
            if (rf_gnt) begin
              if (r_wide) begin
                r_state  <= vp_pkg::BEAT1;
                rf_waddr <= rf_waddr + REG_AW'(1);
                rf_wdata <= r_hi;
              end else begin
                r_state <= vp_pkg::IDLE;
                rf_we   <= 1'b0;
              end
            end
          end
          vp_pkg::BEAT1: begin
            if (rf_gnt) begin
              r_state <= vp_pkg::IDLE;
              rf_we   <= 1'b0;
            end
          end
          default: r_state <= vp_pkg::IDLE;
        endcase
      end
    end
  end

  // High half is pure data and only needs to be valid while a wide result is held.
  always_ff @(posedge clk) begin
    if (w_accept) r_hi <= w_beat1;
  end
endmodule
